// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller for the MEM stage: issues one registered memory
// request per EX/MEM load or store, stalls the pipeline until it completes or times out.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        err,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_d, mem_we_d, rdata_valid_d, err_d;
  logic [31:0] mem_addr_d, mem_wdata_d, rdata_out_d;
  logic [15:0] stall_cycles_d;
  logic        pending, aligned;

  assign pending = mem_read_in | mem_write_in;
  assign aligned = (addr_in[1:0] == 2'b00);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    rdata_out_d   = rdata_out;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    stall         = 1'b0;

    case (state_q)
      StIdle: begin
        if (pending) begin
          if (aligned) begin
            stall       = 1'b1;
            state_d     = StAccess;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            // A simultaneous read+write request is treated as a store.
            mem_we_d    = mem_write_in;
            mem_addr_d  = addr_in;
            mem_wdata_d = wdata_in;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAccess: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          if (!mem_we) begin
            rdata_out_d   = mem_rdata;
            rdata_valid_d = 1'b1;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (!mem_we) begin
            rdata_out_d   = 32'd0;
            rdata_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase

    stall_cycles_d = stall_cycles;
    if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      rdata_out    <= 32'd0;
      rdata_valid  <= 1'b0;
      err          <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      rdata_out    <= rdata_out_d;
      rdata_valid  <= rdata_valid_d;
      err          <= err_d;
      stall_cycles <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a default-TIMEOUT instance and a TIMEOUT=3 instance
// share stimulus; expected values are hand-derived from the cycle timing.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        rd, wr, ack;
  logic [31:0] addr, wdata, rdata;

  logic        req, we, stall, rvalid, err;
  logic [31:0] maddr, mwdata, rout;
  logic [15:0] scyc;

  logic        req3, we3, stall3, rvalid3, err3;
  logic [31:0] maddr3, mwdata3, rout3;
  logic [15:0] scyc3;

  int checks;
  int failures;
  int n;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .mem_read_in(rd), .mem_write_in(wr), .addr_in(addr),
    .wdata_in(wdata), .mem_ack(ack), .mem_rdata(rdata), .mem_req(req), .mem_we(we),
    .mem_addr(maddr), .mem_wdata(mwdata), .stall(stall), .rdata_out(rout),
    .rdata_valid(rvalid), .err(err), .stall_cycles(scyc)
  );

  mem_access_ctrl #(.TIMEOUT(3)) dut3 (
    .clk(clk), .reset(reset), .mem_read_in(rd), .mem_write_in(wr), .addr_in(addr),
    .wdata_in(wdata), .mem_ack(ack), .mem_rdata(rdata), .mem_req(req3), .mem_we(we3),
    .mem_addr(maddr3), .mem_wdata(mwdata3), .stall(stall3), .rdata_out(rout3),
    .rdata_valid(rvalid3), .err(err3), .stall_cycles(scyc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; ack = 1'b0;
    addr = '0; wdata = '0; rdata = '0;
    #2;
    check("rst_req", req, 0);       check("rst_we", we, 0);
    check("rst_addr", maddr, 0);    check("rst_wdata", mwdata, 0);
    check("rst_rdata", rout, 0);    check("rst_rvalid", rvalid, 0);
    check("rst_err", err, 0);       check("rst_scyc", scyc, 0);
    check("rst_stall", stall, 0);
    cyc; cyc; reset = 1'b0;

    // Zero-wait read
    cyc; rd = 1'b1; addr = 32'h100; #2;
    check("rd_c0_stall", stall, 1); check("rd_c0_req", req, 0);
    cyc; ack = 1'b1; rdata = 32'hDEADBEEF; #2;
    check("rd_c1_req", req, 1);     check("rd_c1_we", we, 0);
    check("rd_c1_addr", maddr, 32'h100); check("rd_c1_stall", stall, 1);
    cyc; rd = 1'b0; ack = 1'b0; #2;
    check("rd_c2_rvalid", rvalid, 1); check("rd_c2_rdata", rout, 32'hDEADBEEF);
    check("rd_c2_stall", stall, 0); check("rd_c2_req", req, 0);
    check("rd_c2_scyc", scyc, 2);   check("rd_c2_err", err, 0);
    cyc; #2;
    check("rd_c3_rvalid", rvalid, 0);

    // No ack: TIMEOUT=3 instance expires after 3 cycles, default one after 15
    cyc; rd = 1'b1; addr = 32'h40; #2;
    check("to_c0_stall3", stall3, 1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc;
      if (i == 4) rd = 1'b0;
      #2;
      if (i <= 3) check("to3_req", req3, 1);
      if (i == 4) begin
        check("to3_req_drop", req3, 0); check("to3_err", err3, 1);
        check("to3_rvalid", rvalid3, 1); check("to3_rdata", rout3, 0);
        check("to3_stall", stall3, 0);
      end
      if (i == 5) check("to3_err_pulse", err3, 0);
      if (req) n++;
      if (err) break;
    end
    check("to15_err", err, 1);
    check("to15_req_cycles", n, 15);
    check("to15_rvalid", rvalid, 1);
    check("to15_rdata", rout, 0);
    cyc; #2;
    check("to15_err_pulse", err, 0);

    // Ack on the last legal ACCESS cycle of the TIMEOUT=3 instance
    cyc; rd = 1'b1; addr = 32'h44; #2;
    cyc; #2; cyc; #2;
    cyc; ack = 1'b1; rdata = 32'hCAFE0003; #2;
    check("ackto_req3", req3, 1);
    cyc; rd = 1'b0; ack = 1'b0; #2;
    check("ackto_err3", err3, 0); check("ackto_rvalid3", rvalid3, 1);
    check("ackto_rdata3", rout3, 32'hCAFE0003);
    check("ackto_scyc", scyc, 22);

    // Write with ack in the 4th ACCESS cycle
    cyc; wr = 1'b1; addr = 32'h20; wdata = 32'h12345678; #2;
    check("wr_c0_stall", stall, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc;
      if (i == 4) ack = 1'b1;
      #2;
      check("wr_req", req, 1);        check("wr_we", we, 1);
      check("wr_addr", maddr, 32'h20); check("wr_wdata", mwdata, 32'h12345678);
      check("wr_stall", stall, 1);    check("wr_rvalid", rvalid, 0);
    end
    cyc; wr = 1'b0; ack = 1'b0; #2;
    check("wr_done_rvalid", rvalid, 0); check("wr_done_stall", stall, 0);
    check("wr_done_req", req, 0);       check("wr_scyc", scyc, 27);

    cyc; reset = 1'b1; #2;
    check("rst2_scyc", scyc, 0);
    cyc; reset = 1'b0;

    // Misaligned read
    cyc; rd = 1'b1; addr = 32'h103; #2;
    check("mis_c0_stall", stall, 0); check("mis_c0_req", req, 0);
    cyc; rd = 1'b0; #2;
    check("mis_c1_err", err, 1);     check("mis_c1_req", req, 0);
    cyc; #2;
    check("mis_c2_err", err, 0);     check("mis_c2_req", req, 0);
    check("mis_scyc", scyc, 0);

    // Read+write together is a store; second request follows DONE back-to-back
    cyc; rd = 1'b1; wr = 1'b1; addr = 32'h200; wdata = 32'h0000A5A5; #2;
    cyc; ack = 1'b1; #2;
    check("rw_we", we, 1);           check("rw_wdata", mwdata, 32'h0000A5A5);
    cyc; ack = 1'b0; wr = 1'b0; addr = 32'h300; #2;
    check("b2b_done_stall", stall, 0); check("b2b_done_rvalid", rvalid, 0);
    cyc; #2;
    check("b2b_idle_stall", stall, 1); check("b2b_idle_req", req, 0);
    cyc; ack = 1'b1; rdata = 32'h00000055; #2;
    check("b2b_req", req, 1);        check("b2b_addr", maddr, 32'h300);
    check("b2b_we", we, 0);
    cyc; rd = 1'b0; ack = 1'b0; #2;
    check("b2b_rvalid", rvalid, 1);  check("b2b_rdata", rout, 32'h55);
    check("b2b_scyc", scyc, 4);

    // Reset during ACCESS, then a late ack
    cyc; rd = 1'b1; addr = 32'h400; #2;
    cyc; #2;
    check("rma_req_before", req, 1);
    reset = 1'b1; #1;
    check("rma_req_async", req, 0);
    cyc; rd = 1'b0; reset = 1'b0; ack = 1'b1; rdata = 32'h77; #2;
    for (int i = 0; i < 2; i++) begin
      cyc; #2;
      check("rma_req", req, 0);      check("rma_rvalid", rvalid, 0);
      check("rma_stall", stall, 0);  check("rma_err", err, 0);
    end
    ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
